// File: rtl/dp_share_ctrl_pkg.sv
// Shared types and constants for the data_path sharing controller.
package dp_ctrl_pkg;

  localparam int DP_W     = 8;
  localparam int DP_LAT   = 2;
  localparam int ID_MAX_W = 3;

  function automatic int id_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  typedef struct packed {
    logic                valid;
    logic [ID_MAX_W-1:0] id;
  } tag_t;

  typedef struct packed {
    logic [ID_MAX_W-1:0] id;
    logic [DP_W-1:0]     data;
  } rsp_t;

endpackage

// File: rtl/dp_share_ctrl_rr_arbiter.sv
// Combinational round-robin search: first requester at or above ptr, wrapping modulo N.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic          enable,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx
);

  logic [IW:0] pos;
  logic        found;

  // priority search starting at ptr
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    pos     = '0;
    for (int off = 0; off < N; off++) begin
      pos = {1'b0, ptr} + (IW+1)'(off);
      if (pos >= (IW+1)'(N)) begin
        pos = pos - (IW+1)'(N);
      end else begin
        pos = pos;
      end
      if (enable && !found && req[pos[IW-1:0]]) begin
        gnt[pos[IW-1:0]] = 1'b1;
        gnt_idx          = pos[IW-1:0];
        found            = 1'b1;
      end else begin
        found = found;
      end
    end
  end

endmodule

// File: rtl/dp_share_ctrl.sv
// Shares one fixed-latency data_path between NUM_REQ requesters: round-robin issue,
// owner tags carried alongside the pipe, credit-gated response FIFO.
module dp_share_ctrl
  import dp_ctrl_pkg::*;
#(
  parameter int  NUM_REQ    = 4,
  parameter int  FIFO_DEPTH = 4,
  localparam int ID_W       = id_width(NUM_REQ)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    cfg_enable,
  input  logic [NUM_REQ-1:0]      req_valid,
  input  logic [NUM_REQ*DP_W-1:0] req_data,
  output logic [NUM_REQ-1:0]      req_ready,
  output logic [DP_W-1:0]         dp_data_in,
  output logic                    dp_valid_in,
  input  logic [DP_W-1:0]         dp_data_out,
  input  logic                    dp_valid_out,
  output logic                    rsp_valid,
  output logic [ID_W-1:0]         rsp_id,
  output logic [DP_W-1:0]         rsp_data,
  input  logic                    rsp_ready,
  output logic                    busy,
  output logic                    err_tag
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  logic [NUM_REQ-1:0] gnt_s;
  logic [ID_W-1:0]    gnt_idx_s;
  logic               gnt_any_s;
  logic               can_issue_s;
  logic [CW-1:0]      inflight_s;
  logic [CW:0]        credit_use_s;
  logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
  tag_t               tag_q [DP_LAT];
  tag_t               tag_d [DP_LAT];
  tag_t               head_s;
  rsp_t               mem_q [FIFO_DEPTH];
  rsp_t               mem_d [FIFO_DEPTH];
  rsp_t               rsp_head_s;
  logic [PW-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               err_q, err_d;
  logic               full_s, push_s, pop_s, mismatch_s;
  logic               unused_id_s;

  // credit: queued plus in-flight words must leave room for every outstanding result
  always_comb begin
    inflight_s = '0;
    for (int i = 0; i < DP_LAT; i++) begin
      inflight_s = inflight_s + CW'(tag_q[i].valid);
    end
    credit_use_s = {1'b0, cnt_q} + {1'b0, inflight_s};
    // rst_n gating keeps req_ready low while reset is held
    can_issue_s  = rst_n & cfg_enable & (credit_use_s < (CW+1)'(FIFO_DEPTH));
  end

  rr_arbiter #(.N(NUM_REQ), .IW(ID_W)) u_arb (
    .req     (req_valid),
    .enable  (can_issue_s),
    .ptr     (rr_ptr_q),
    .gnt     (gnt_s),
    .gnt_idx (gnt_idx_s)
  );

  assign gnt_any_s = |gnt_s;

  always_comb begin
    req_ready   = gnt_s;
    dp_valid_in = gnt_any_s;
    dp_data_in  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt_s[i]) begin
        dp_data_in = req_data[i*DP_W +: DP_W];
      end else begin
        dp_data_in = dp_data_in;
      end
    end
    rr_ptr_d = rr_ptr_q;
    if (gnt_any_s) begin
      rr_ptr_d = (gnt_idx_s == ID_W'(NUM_REQ - 1)) ? '0 : gnt_idx_s + ID_W'(1);
    end else begin
      rr_ptr_d = rr_ptr_q;
    end
    // data_path has no enable, so the tag pipe shifts every cycle
    tag_d[0].valid = gnt_any_s;
    tag_d[0].id    = ID_MAX_W'(gnt_idx_s);
    for (int i = 1; i < DP_LAT; i++) begin
      tag_d[i] = tag_q[i-1];
    end
  end

  assign head_s     = tag_q[DP_LAT-1];
  assign full_s     = (cnt_q == CW'(FIFO_DEPTH));
  assign mismatch_s = (head_s.valid != dp_valid_out);
  assign push_s     = dp_valid_out & ~full_s;
  assign pop_s      = rsp_valid & rsp_ready;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_s) begin
      mem_d[wr_ptr_q].id   = head_s.valid ? head_s.id : '0;
      mem_d[wr_ptr_q].data = dp_data_out;
      wr_ptr_d             = wr_ptr_q + PW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_s, pop_s})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
    err_d = err_q | mismatch_s | (dp_valid_out & full_s);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
      for (int i = 0; i < DP_LAT; i++) begin
        tag_q[i] <= '0;
      end
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      rr_ptr_q <= rr_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
      tag_q    <= tag_d;
      mem_q    <= mem_d;
    end
  end

  assign rsp_head_s  = mem_q[rd_ptr_q];
  assign rsp_valid   = (cnt_q != '0);
  assign rsp_id      = rsp_valid ? rsp_head_s.id[ID_W-1:0] : '0;
  assign rsp_data    = rsp_valid ? rsp_head_s.data : '0;
  assign busy        = (inflight_s != '0) | (cnt_q != '0);
  assign err_tag     = err_q;
  assign unused_id_s = ^rsp_head_s.id;

endmodule

// File: tb/tb_dp_share_ctrl.sv
// Scoreboard bench for dp_share_ctrl with a two-stage data_path model:
// stage 1 flips the low nibble, stage 2 ORs bit 7 into the low nibble.
module tb_dp_share_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cfg_enable = 1'b1;
  logic [3:0]  req_valid = 4'h0;
  logic [31:0] req_data = 32'h0;
  logic [3:0]  req_ready;
  logic [7:0]  dp_data_in;
  logic        dp_valid_in;
  logic [7:0]  dp_data_out;
  logic        dp_valid_out;
  logic        rsp_valid;
  logic [1:0]  rsp_id;
  logic [7:0]  rsp_data;
  logic        rsp_ready = 1'b0;
  logic        busy;
  logic        err_tag;
  logic        fault_inj = 1'b0;

  logic [7:0]  s1_d, s2_d;
  logic        s1_v, s2_v;

  typedef struct {
    logic [1:0] id;
    logic [7:0] data;
  } exp_t;
  exp_t exp_q[$];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dp_share_ctrl #(.NUM_REQ(4), .FIFO_DEPTH(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cfg_enable   (cfg_enable),
    .req_valid    (req_valid),
    .req_data     (req_data),
    .req_ready    (req_ready),
    .dp_data_in   (dp_data_in),
    .dp_valid_in  (dp_valid_in),
    .dp_data_out  (dp_data_out),
    .dp_valid_out (dp_valid_out),
    .rsp_valid    (rsp_valid),
    .rsp_id       (rsp_id),
    .rsp_data     (rsp_data),
    .rsp_ready    (rsp_ready),
    .busy         (busy),
    .err_tag      (err_tag)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v <= 1'b0; s1_d <= 8'h00; s2_v <= 1'b0; s2_d <= 8'h00;
    end else begin
      s1_v <= dp_valid_in;
      s1_d <= dp_data_in ^ 8'h0F;
      s2_v <= s1_v;
      s2_d <= s1_d | {4'h0, {4{s1_d[7]}}};
    end
  end

  assign dp_data_out  = s2_d;
  assign dp_valid_out = s2_v | fault_inj;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_rsp(input logic [1:0] id, input logic [7:0] data);
    exp_t e;
    e.id = id;
    e.data = data;
    exp_q.push_back(e);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; req_valid = 4'h0; cfg_enable = 1'b1; rsp_ready = 1'b0; fault_inj = 1'b0;
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic drain(input string name);
    rsp_ready = 1'b1;
    req_valid = 4'h0;
    for (int i = 0; i < 40 && (exp_q.size() != 0 || busy); i++) next_cycle();
    chk({name, "_drained"}, exp_q.size(), 0);
    @(negedge clk);
    chk({name, "_busy_low"}, busy, 0);
    next_cycle();
  endtask

  // scoreboard monitor: every accepted response must match the oldest expectation
  always @(negedge clk) begin
    if (rst_n && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rsp: got id %0d data 0x%0h, expected no response", rsp_id, rsp_data);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("rsp_id", rsp_id, e.id);
        chk("rsp_data", rsp_data, e.data);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    // reset values
    do_reset();
    @(negedge clk);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_dp_valid_in", dp_valid_in, 0);
    chk("rst_dp_data_in", dp_data_in, 8'h00);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_id", rsp_id, 0);
    chk("rst_rsp_data", rsp_data, 8'h00);
    chk("rst_busy", busy, 0);
    chk("rst_err_tag", err_tag, 0);
    next_cycle();

    // single issue from requester 2
    rsp_ready = 1'b1;
    req_data  = 32'h0081_0000;
    req_valid = 4'b0100;
    expect_rsp(2'd2, 8'h8F);
    @(negedge clk);
    chk("single_grant", req_ready, 4'b0100);
    chk("single_dp_valid", dp_valid_in, 1);
    chk("single_dp_data", dp_data_in, 8'h81);
    next_cycle();
    req_valid = 4'h0;
    @(negedge clk);
    chk("single_t1_rsp_valid", rsp_valid, 0);
    chk("single_t1_busy", busy, 1);
    chk("single_idle_dp_data", dp_data_in, 8'h00);
    next_cycle();
    @(negedge clk);
    chk("single_t2_rsp_valid", rsp_valid, 0);
    next_cycle();
    @(negedge clk);
    chk("single_t3_rsp_valid", rsp_valid, 1);
    next_cycle();
    @(negedge clk);
    chk("single_t4_busy", busy, 0);
    chk("single_t4_rsp_valid", rsp_valid, 0);
    next_cycle();

    // round-robin fairness at full throughput
    do_reset();
    rsp_ready = 1'b1;
    req_data  = 32'h810F_FF00;
    req_valid = 4'hF;
    for (int r = 0; r < 2; r++) begin
      expect_rsp(2'd0, 8'h0F);
      expect_rsp(2'd1, 8'hFF);
      expect_rsp(2'd2, 8'h00);
      expect_rsp(2'd3, 8'h8F);
    end
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("rr_grant", req_ready, 4'b0001 << (i % 4));
      next_cycle();
    end
    drain("rr");

    // backpressure: credit stall and single-pop regrant
    do_reset();
    req_data  = 32'h810F_FF00;
    req_valid = 4'hF;
    expect_rsp(2'd0, 8'h0F);
    expect_rsp(2'd1, 8'hFF);
    expect_rsp(2'd2, 8'h00);
    expect_rsp(2'd3, 8'h8F);
    expect_rsp(2'd0, 8'h0F);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("bp_grant", req_ready, 4'b0001 << i);
      next_cycle();
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("bp_stall", req_ready, 0);
      next_cycle();
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp_full_stall", req_ready, 0);
    chk("bp_rsp_valid", rsp_valid, 1);
    next_cycle();
    rsp_ready = 1'b0;
    @(negedge clk);
    chk("bp_regrant", req_ready, 4'b0001);
    next_cycle();
    @(negedge clk);
    chk("bp_restall", req_ready, 0);
    next_cycle();
    drain("bp");

    // cfg_enable dropped after two grants
    do_reset();
    rsp_ready = 1'b1;
    req_data  = 32'h810F_FF00;
    req_valid = 4'hF;
    expect_rsp(2'd0, 8'h0F);
    expect_rsp(2'd1, 8'hFF);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("cfg_grant", req_ready, 4'b0001 << i);
      next_cycle();
    end
    cfg_enable = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("cfg_no_grant", req_ready, 0);
      chk("cfg_no_issue", dp_valid_in, 0);
      next_cycle();
    end
    drain("cfg");

    // reset with two words in flight and two queued
    do_reset();
    req_data  = 32'h810F_FF00;
    req_valid = 4'hF;
    repeat (4) next_cycle();
    @(negedge clk);
    chk("mid_busy_before", busy, 1);
    chk("mid_rsp_valid_before", rsp_valid, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_req_ready", req_ready, 0);
    chk("mid_rst_dp_valid_in", dp_valid_in, 0);
    chk("mid_rst_dp_data_in", dp_data_in, 8'h00);
    chk("mid_rst_rsp_valid", rsp_valid, 0);
    chk("mid_rst_rsp_id", rsp_id, 0);
    chk("mid_rst_rsp_data", rsp_data, 8'h00);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_err_tag", err_tag, 0);
    req_valid = 4'h0;
    rsp_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("post_rst_rsp_valid", rsp_valid, 0);
      chk("post_rst_err_tag", err_tag, 0);
      next_cycle();
    end

    // fault: valid from data_path with no tag in flight
    fault_inj = 1'b1;
    expect_rsp(2'd0, 8'h0F);
    @(negedge clk);
    chk("fault_err_before", err_tag, 0);
    next_cycle();
    fault_inj = 1'b0;
    @(negedge clk);
    chk("fault_err_set", err_tag, 1);
    chk("fault_rsp_valid", rsp_valid, 1);
    next_cycle();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("fault_err_sticky", err_tag, 1);
      next_cycle();
    end
    chk("fault_queue_empty", exp_q.size(), 0);
    rst_n = 1'b0;
    #1;
    chk("fault_err_cleared", err_tag, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    next_cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
